vga_timing_regs: RTL and testbench



---
 rtl/vga_timing_regs.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_regs.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_regs.sv
// vga_timing_regs: AXI4-Lite bank of double-buffered VGA timing registers; define VGA_TIMING_REGS_IRQ_EN for the frame interrupt
package vga_pkg;
  typedef struct packed {
    logic [31:0] H_RES;
    logic [31:0] H_FRONT_PORCH;
    logic [31:0] H_SYNC_PULSE;
    logic [31:0] H_BACK_PORCH;
    logic [31:0] V_RES;
    logic [31:0] V_FRONT_PORCH;
    logic [31:0] V_SYNC_PULSE;
    logic [31:0] V_BACK_PORCH;
  } vga_config_t;
  localparam vga_config_t vga_configs [5] = '{
    '{640, 16, 96, 48, 480, 10, 2, 33},
    '{800, 40, 128, 88, 600, 1, 4, 23},
    '{1024, 24, 136, 160, 768, 3, 6, 29},
    '{1280, 110, 40, 220, 720, 5, 5, 20},
    '{1920, 88, 44, 148, 1080, 4, 5, 36}
  };
endpackage

module vga_timing_regs #(
  parameter int          DEFAULT_CONFIG = 3,
  parameter int          ADDR_WIDTH     = 12,
  parameter int          TW             = 16,
  parameter logic [31:0] ID_VALUE       = 32'h5647_4132
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] ctrl_araddr,
  input  logic                  ctrl_arvalid,
  output logic                  ctrl_arready,
  output logic [31:0]           ctrl_rdata,
  output logic [1:0]            ctrl_rresp,
  output logic                  ctrl_rvalid,
  input  logic                  ctrl_rready,
  input  logic [ADDR_WIDTH-1:0] ctrl_awaddr,
  input  logic                  ctrl_awvalid,
  output logic                  ctrl_awready,
  input  logic [31:0]           ctrl_wdata,
  input  logic [3:0]            ctrl_wstrb,
  input  logic                  ctrl_wvalid,
  output logic                  ctrl_wready,
  output logic [1:0]            ctrl_bresp,
  output logic                  ctrl_bvalid,
  input  logic                  ctrl_bready,
  input  logic                  frame_start,
  output logic                  enable,
  output logic [TW-1:0]         h_res,
  output logic [TW-1:0]         h_front_porch,
  output logic [TW-1:0]         h_sync_pulse,
  output logic [TW-1:0]         h_back_porch,
  output logic [TW-1:0]         v_res,
  output logic [TW-1:0]         v_front_porch,
  output logic [TW-1:0]         v_sync_pulse,
  output logic [TW-1:0]         v_back_porch,
  output logic                  irq
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam vga_pkg::vga_config_t CFG = vga_pkg::vga_configs[DEFAULT_CONFIG];
  localparam logic [31:0] RST [8] = '{CFG.H_RES, CFG.H_FRONT_PORCH, CFG.H_SYNC_PULSE, CFG.H_BACK_PORCH,
                                      CFG.V_RES, CFG.V_FRONT_PORCH, CFG.V_SYNC_PULSE, CFG.V_BACK_PORCH};

  logic          aw_held, w_held, en, pending;
  logic [AW-1:0] aw_idx, ar_idx;
  logic [31:0]   w_data, rd_word;
  logic [3:0]    w_strb;
  logic [15:0]   frame_count;
  logic [TW-1:0] shadow [8];
  logic [TW-1:0] active [8];
  logic          irq_pend, irq_en_q;
  logic          wr_fire, ctrl_we, commit, wr_err, rd_err, unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  assign ar_idx       = ctrl_araddr[ADDR_WIDTH-1:2];
  assign unused_addr  = ^{ctrl_araddr[1:0], ctrl_awaddr[1:0]};
  assign ctrl_arready = !ctrl_rvalid;
  assign ctrl_awready = !aw_held && !ctrl_bvalid;
  assign ctrl_wready  = !w_held && !ctrl_bvalid;
  assign wr_fire      = aw_held && w_held;
  assign ctrl_we      = wr_fire && aw_idx == AW'(1) && w_strb[0];
  assign commit       = ctrl_we && w_data[1];
  assign wr_err       = aw_idx == AW'(0) || aw_idx > AW'(11);
  assign rd_err       = ar_idx > AW'(11);
  assign rd_word      = ar_idx == AW'(0) ? ID_VALUE :
                        ar_idx == AW'(1) ? {30'd0, pending, en} :
                        ar_idx == AW'(2) ? {frame_count, 7'd0, irq_pend, 7'd0, pending} :
                        ar_idx == AW'(3) ? {31'd0, irq_en_q} :
                        !rd_err          ? 32'(shadow[3'(ar_idx - AW'(4))]) : 32'd0;

  assign enable        = en;
  assign h_res         = active[0];
  assign h_front_porch = active[1];
  assign h_sync_pulse  = active[2];
  assign h_back_porch  = active[3];
  assign v_res         = active[4];
  assign v_front_porch = active[5];
  assign v_sync_pulse  = active[6];
  assign v_back_porch  = active[7];

  // AXI channels, control/shadow writes, and frame-boundary transfer of shadow into active
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      ctrl_rvalid <= 1'b0;
      ctrl_rdata  <= '0;
      ctrl_rresp  <= '0;
      ctrl_bvalid <= 1'b0;
      ctrl_bresp  <= '0;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx      <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      en          <= 1'b0;
      pending     <= 1'b0;
      frame_count <= '0;
      for (int k = 0; k < 8; k++) begin
        shadow[k] <= TW'(RST[k]);
        active[k] <= TW'(RST[k]);
      end
    end else begin
      if (ctrl_arvalid && ctrl_arready) begin
        ctrl_rvalid <= 1'b1;
        ctrl_rdata  <= rd_word;
        ctrl_rresp  <= rd_err ? 2'b10 : 2'b00;
      end else if (ctrl_rvalid && ctrl_rready) ctrl_rvalid <= 1'b0;
      if (ctrl_awvalid && ctrl_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= ctrl_awaddr[ADDR_WIDTH-1:2];
      end
      if (ctrl_wvalid && ctrl_wready) begin
        w_held <= 1'b1;
        w_data <= ctrl_wdata;
        w_strb <= ctrl_wstrb;
      end
      if (wr_fire) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        ctrl_bvalid <= 1'b1;
        ctrl_bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (ctrl_bvalid && ctrl_bready) ctrl_bvalid <= 1'b0;
      if (ctrl_we) en <= w_data[0];
      if (commit) pending <= 1'b1;
      else if (frame_start) pending <= 1'b0;
      if (frame_start && pending) active <= shadow;
      frame_count <= frame_count + {15'd0, frame_start};
      for (int k = 0; k < 8; k++)
        if (wr_fire && aw_idx == AW'(k + 4)) shadow[k] <= TW'(merge(32'(shadow[k]), w_data, w_strb));
    end

`ifdef VGA_TIMING_REGS_IRQ_EN
  logic irq_q, irq_clr, irq_en_we, irq_pend_n, irq_en_n;
  assign irq_clr    = wr_fire && aw_idx == AW'(2) && w_strb[1] && w_data[8];
  assign irq_en_we  = wr_fire && aw_idx == AW'(3) && w_strb[0];
  assign irq_pend_n = frame_start || (irq_pend && !irq_clr);
  assign irq_en_n   = irq_en_we ? w_data[0] : irq_en_q;
  assign irq        = irq_q;

  // Frame interrupt: a new frame wins over a coincident W1C clear
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      irq_pend <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_pend <= irq_pend_n;
      irq_en_q <= irq_en_n;
      irq_q    <= irq_pend_n && irq_en_n;
    end
`else
  assign irq_pend = 1'b0;
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_regs.sv
// tb_vga_timing_regs: randomized bench for vga_timing_regs against a register-level model
module tb_vga_timing_regs;
  localparam int TW = 16;
  localparam logic [31:0] MASK = 32'h0000_FFFF;
  localparam int OW = 2 + 8 * TW;
`ifdef VGA_TIMING_REGS_IRQ_EN
  localparam bit IRQB = 1'b1;
`else
  localparam bit IRQB = 1'b0;
`endif
  localparam logic [31:0] PRESET [8] = '{1280, 110, 40, 220, 720, 5, 5, 20};

  logic aclk = 1'b0, areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [11:0] ctrl_araddr = '0, ctrl_awaddr = '0;
  logic ctrl_arvalid = 1'b0, ctrl_rready = 1'b1, ctrl_awvalid = 1'b0, ctrl_wvalid = 1'b0, ctrl_bready = 1'b1;
  logic ctrl_arready, ctrl_rvalid, ctrl_awready, ctrl_wready, ctrl_bvalid;
  logic [31:0] ctrl_rdata, ctrl_wdata = '0;
  logic [1:0] ctrl_rresp, ctrl_bresp;
  logic [3:0] ctrl_wstrb = '0;
  logic frame_start = 1'b0, enable, irq;
  logic [TW-1:0] h_res, h_front_porch, h_sync_pulse, h_back_porch, v_res, v_front_porch, v_sync_pulse, v_back_porch;

  vga_timing_regs #(.DEFAULT_CONFIG(3), .ADDR_WIDTH(12), .TW(TW), .ID_VALUE(32'h5647_4132)) dut (
    .aclk(aclk), .areset(areset),
    .ctrl_araddr(ctrl_araddr), .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready),
    .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp), .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready),
    .ctrl_awaddr(ctrl_awaddr), .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready),
    .ctrl_wdata(ctrl_wdata), .ctrl_wstrb(ctrl_wstrb), .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready),
    .ctrl_bresp(ctrl_bresp), .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready),
    .frame_start(frame_start), .enable(enable),
    .h_res(h_res), .h_front_porch(h_front_porch), .h_sync_pulse(h_sync_pulse), .h_back_porch(h_back_porch),
    .v_res(v_res), .v_front_porch(v_front_porch), .v_sync_pulse(v_sync_pulse), .v_back_porch(v_back_porch),
    .irq(irq)
  );

  int checks = 0, errors = 0;
  logic [31:0] m_sh [8];
  logic [31:0] m_act [8];
  bit m_en, m_pend, m_irqp, m_irqen, chk_en = 1'b0;
  logic [15:0] m_fc;
  bit m_wr = 1'b0;
  logic [11:0] m_wa = '0;
  logic [31:0] m_wd = '0;
  logic [3:0] m_ws = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic m_reset;
    for (int k = 0; k < 8; k++) begin
      m_sh[k] = PRESET[k];
      m_act[k] = PRESET[k];
    end
    m_en = 0; m_pend = 0; m_irqp = 0; m_irqen = 0; m_fc = 0;
  endtask

  task automatic m_read(input logic [11:0] a, output logic [31:0] v, output logic [1:0] r);
    int i = int'(a[11:2]);
    r = 2'b00;
    case (i)
      0: v = 32'h5647_4132;
      1: v = {30'd0, m_pend, m_en};
      2: v = {m_fc, 7'd0, m_irqp, 7'd0, m_pend};
      3: v = {31'd0, m_irqen};
      4, 5, 6, 7, 8, 9, 10, 11: v = m_sh[i-4];
      default: begin v = 0; r = 2'b10; end
    endcase
  endtask

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input bit fs);
    int i = int'(a[11:2]);
    if (i == 1 && s[0]) begin
      m_en = d[0];
      if (d[1]) m_pend = 1;
    end
    if (IRQB && i == 2 && s[1] && d[8] && !fs) m_irqp = 0;
    if (IRQB && i == 3 && s[0]) m_irqen = d[0];
    if (i >= 4 && i <= 11) m_sh[i-4] = bytes_merge(m_sh[i-4], d, s) & MASK;
  endtask

  // Model: frame boundary applies the old shadow, then the write of the same edge lands
  always @(posedge aclk or posedge areset)
    if (areset) m_reset();
    else begin
      if (frame_start && m_pend) m_act = m_sh;
      if (frame_start) begin
        m_pend = 0;
        m_fc = m_fc + 16'd1;
        m_irqp = IRQB;
      end
      if (m_wr) m_write(m_wa, m_wd, m_ws, frame_start);
    end

  // Compare all generator-facing outputs every cycle
  always @(negedge aclk) if (chk_en) begin
    logic [OW-1:0] got, exp;
    got = {enable, irq, h_res, h_front_porch, h_sync_pulse, h_back_porch, v_res, v_front_porch, v_sync_pulse, v_back_porch};
    exp = {m_en, m_irqp && m_irqen, TW'(m_act[0]), TW'(m_act[1]), TW'(m_act[2]), TW'(m_act[3]),
           TW'(m_act[4]), TW'(m_act[5]), TW'(m_act[6]), TW'(m_act[7])};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs: got %h expected %h at %0t", got, exp, $time);
    end
  end

  task automatic axi_read(input logic [11:0] a, input bit stall, output logic [31:0] got);
    logic [31:0] ev;
    logic [1:0] er;
    @(negedge aclk);
    m_read(a, ev, er);
    chk("arready", ctrl_arready, 1);
    ctrl_araddr = a;
    ctrl_arvalid = 1;
    @(posedge aclk); #1;
    ctrl_arvalid = 0;
    if (stall) ctrl_rready = 0;
    chk("rvalid", ctrl_rvalid, 1);
    chk("rdata", ctrl_rdata, ev);
    chk("rresp", ctrl_rresp, er);
    chk("arready_busy", ctrl_arready, 0);
    got = ctrl_rdata;
    if (stall) begin
      @(posedge aclk); #1;
      chk("rvalid_hold", ctrl_rvalid, 1);
      chk("rdata_hold", ctrl_rdata, ev);
      ctrl_rready = 1;
    end
    @(posedge aclk); #1;
    chk("rvalid_clr", ctrl_rvalid, 0);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int lead, input bit fs);
    int tw, ta, we;
    logic [1:0] er;
    er = (a[11:2] == 0 || a[11:2] > 11) ? 2'b10 : 2'b00;
    tw = lead > 0 ? 0 : -lead;
    ta = lead > 0 ? lead : 0;
    we = (tw > ta ? tw : ta) + 1;
    for (int e = 0; e <= we; e++) begin
      @(negedge aclk);
      ctrl_awvalid = (e == ta);
      ctrl_wvalid = (e == tw);
      ctrl_awaddr = a;
      ctrl_wdata = d;
      ctrl_wstrb = s;
      if (e == ta) chk("awready", ctrl_awready, 1);
      if (e == tw) chk("wready", ctrl_wready, 1);
      m_wr = (e == we);
      m_wa = a; m_wd = d; m_ws = s;
      frame_start = fs && (e == we);
      @(posedge aclk); #1;
      chk(e == we ? "bvalid" : "bvalid_early", ctrl_bvalid, e == we);
    end
    ctrl_awvalid = 0;
    ctrl_wvalid = 0;
    chk("bresp", ctrl_bresp, er);
    chk("aw_w_ready_busy", {ctrl_awready, ctrl_wready}, 0);
    @(negedge aclk);
    m_wr = 0;
    frame_start = 0;
    @(posedge aclk); #1;
    chk("bvalid_clr", ctrl_bvalid, 0);
  endtask

  task automatic pulse;
    @(negedge aclk); frame_start = 1;
    @(negedge aclk); frame_start = 0;
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int cnt;
    repeat (3) @(negedge aclk);
    areset = 0;
    chk_en = 1;
    chk("rst_h_res", h_res, 1280);
    chk("rst_v_bp", v_back_porch, 20);
    chk("rst_en_irq", {enable, irq}, 0);
    chk("rst_valids", {ctrl_rvalid, ctrl_bvalid}, 0);
    chk("rst_readies", {ctrl_arready, ctrl_awready, ctrl_wready}, 3'b111);
    axi_read(12'h000, 0, got);
    chk("id", got, 32'h5647_4132);
    axi_read(12'h010, 0, got);
    chk("shadow_preset", got, 1280);
    // Shadow write only reaches outputs via commit + frame
    axi_write(12'h010, 32'h0320, 4'hF, 2, 0);
    chk("h_res_no_commit", h_res, 1280);
    pulse();
    chk("h_res_frame_no_pend", h_res, 1280);
    axi_write(12'h004, 32'h3, 4'h1, -1, 0);
    chk("enable_set", enable, 1);
    axi_read(12'h008, 0, got);
    chk("pending_set", got[0], 1);
    pulse();
    chk("h_res_commit", h_res, 32'h0320);
    axi_read(12'h008, 1, got);
    chk("pending_clr", got[0], 0);
    // Byte strobes and TW truncation
    axi_write(12'h014, 32'h10, 4'hF, 0, 0);
    axi_write(12'h014, 32'hAABB_1234, 4'b0001, 1, 0);
    axi_read(12'h014, 0, got);
    chk("strb_low", got, 32'h34);
    axi_write(12'h014, 32'hAABB_1234, 4'b1100, 0, 0);
    axi_read(12'h014, 0, got);
    chk("strb_high", got, 32'h34);
    axi_write(12'h014, 32'hAABB_1234, 4'hF, 0, 0);
    axi_read(12'h014, 0, got);
    chk("tw_trunc", got, 32'h1234);
    // Unmapped and read-only accesses
    axi_read(12'h100, 0, got);
    chk("unmapped_rdata", got, 0);
    axi_write(12'h000, 32'h1234_5678, 4'hF, 0, 0);
    axi_read(12'h000, 0, got);
    chk("id_unchanged", got, 32'h5647_4132);
    // Commit on the frame edge is deferred to the next frame
    axi_write(12'h010, 32'h0400, 4'hF, 0, 0);
    axi_write(12'h004, 32'h3, 4'h1, 0, 1);
    chk("commit_coincident", h_res, 32'h0320);
    axi_read(12'h008, 0, got);
    chk("pending_coincident", got[0], 1);
    pulse();
    chk("commit_next_frame", h_res, 32'h0400);
    // Shadow write on the apply edge: active takes the old shadow
    axi_write(12'h004, 32'h3, 4'h1, 0, 0);
    axi_write(12'h018, 32'h99, 4'hF, 0, 1);
    chk("apply_pre_write", h_sync_pulse, 40);
    axi_write(12'h004, 32'h3, 4'h1, 0, 0);
    pulse();
    chk("apply_later", h_sync_pulse, 32'h99);
`ifdef VGA_TIMING_REGS_IRQ_EN
    axi_write(12'h00C, 32'h1, 4'h1, 0, 0);
    pulse();
    chk("irq_set", irq, 1);
    axi_write(12'h008, 32'h100, 4'b0010, 0, 1);
    chk("irq_set_wins", irq, 1);
    axi_write(12'h008, 32'h100, 4'b0010, 0, 0);
    chk("irq_w1c", irq, 0);
`else
    axi_write(12'h00C, 32'h1, 4'h1, 0, 0);
    axi_read(12'h00C, 0, got);
    chk("irq_en_absent", got, 0);
    pulse();
    chk("irq_tied", irq, 0);
`endif
    // Reset in the middle of a read and a write
    @(negedge aclk);
    ctrl_araddr = 12'h010; ctrl_arvalid = 1;
    ctrl_awaddr = 12'h010; ctrl_awvalid = 1;
    ctrl_wdata = 32'h7777; ctrl_wstrb = 4'hF; ctrl_wvalid = 1;
    @(posedge aclk); #1;
    ctrl_arvalid = 0; ctrl_awvalid = 0; ctrl_wvalid = 0; ctrl_rready = 0;
    chk("mid_rvalid", ctrl_rvalid, 1);
    areset = 1; #1;
    chk("mid_rst_rvalid", ctrl_rvalid, 0);
    chk("mid_rst_readies", {ctrl_awready, ctrl_wready, ctrl_arready}, 3'b111);
    @(negedge aclk);
    areset = 0; ctrl_rready = 1;
    @(posedge aclk); #1;
    chk("mid_rst_discard", ctrl_bvalid, 0);
    axi_read(12'h010, 0, got);
    chk("mid_rst_shadow", got, 1280);
    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int op = int'($urandom_range(0, 9));
      int idx = int'($urandom_range(0, 15));
      logic [11:0] a;
      if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(16, 1023));
      a = 12'(idx * 4);
      if (op < 4) axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2, $urandom_range(0, 3) == 0);
      else if (op < 8) axi_read(a, $urandom_range(0, 3) == 0, got);
      else pulse();
    end
    // frame_count wrap
    cnt = int'(16'hFFFF - m_fc);
    @(negedge aclk); frame_start = 1;
    repeat (cnt) @(negedge aclk);
    frame_start = 0;
    axi_read(12'h008, 0, got);
    chk("fc_max", got[31:16], 16'hFFFF);
    pulse();
    axi_read(12'h008, 0, got);
    chk("fc_wrap", got[31:16], 0);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
